// File: rtl/lmmi_initiator.sv
// Fabric-side LMMI initiator: one outstanding register read/write between a valid/ready
// command/response port and a hard-IP LMMI target. Optional watchdog: define LMMI_TIMEOUT_EN.
module lmmi_initiator #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              lmmi_clk,
    input  logic              lmmi_resetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              lmmi_request,
    output logic              lmmi_wr_rdn,
    output logic [ADDR_W-1:0] lmmi_offset,
    output logic [DATA_W-1:0] lmmi_wdata,
    input  logic              lmmi_ready,
    input  logic              lmmi_rdata_valid,
    input  logic [DATA_W-1:0] lmmi_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WAIT_RD = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                cmd_ready_d, rsp_valid_d, rsp_err_d;
    logic                lmmi_request_d, lmmi_wr_rdn_d;
    logic [DATA_W-1:0]   rsp_rdata_d, lmmi_wdata_d;
    logic [ADDR_W-1:0]   lmmi_offset_d;
    logic                timeout_hit;

`ifdef LMMI_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);
    logic [15:0] wd_cnt_q;

    // REQ is only entered from IDLE, so clearing in IDLE clears on entry to REQ.
    always_ff @(posedge lmmi_clk or negedge lmmi_resetn) begin
        if (!lmmi_resetn) begin
            wd_cnt_q <= '0;
        end else if (state_q == IDLE) begin
            wd_cnt_q <= '0;
        end else if ((state_q == REQ || state_q == WAIT_RD) && wd_cnt_q != 16'hFFFF) begin
            wd_cnt_q <= wd_cnt_q + 16'd1;
        end
    end

    assign timeout_hit = (wd_cnt_q >= TIMEOUT_CNT);
`else
    // Legal TIMEOUT is positive, so this is a constant 0: the FSM waits indefinitely.
    assign timeout_hit = (TIMEOUT < 0);
`endif

    always_ff @(posedge lmmi_clk or negedge lmmi_resetn) begin
        if (!lmmi_resetn) begin
            state_q      <= IDLE;
            cmd_ready    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
            lmmi_request <= 1'b0;
            lmmi_wr_rdn  <= 1'b0;
            lmmi_offset  <= '0;
            lmmi_wdata   <= '0;
        end else begin
            state_q      <= state_d;
            cmd_ready    <= cmd_ready_d;
            rsp_valid    <= rsp_valid_d;
            rsp_rdata    <= rsp_rdata_d;
            rsp_err      <= rsp_err_d;
            lmmi_request <= lmmi_request_d;
            lmmi_wr_rdn  <= lmmi_wr_rdn_d;
            lmmi_offset  <= lmmi_offset_d;
            lmmi_wdata   <= lmmi_wdata_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        rsp_valid_d    = rsp_valid;
        rsp_rdata_d    = rsp_rdata;
        rsp_err_d      = rsp_err;
        lmmi_request_d = lmmi_request;
        lmmi_wr_rdn_d  = lmmi_wr_rdn;
        lmmi_offset_d  = lmmi_offset;
        lmmi_wdata_d   = lmmi_wdata;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    lmmi_request_d = 1'b1;
                    lmmi_wr_rdn_d  = cmd_write;
                    lmmi_offset_d  = cmd_addr;
                    lmmi_wdata_d   = cmd_wdata;
                    state_d        = REQ;
                end
            end
            REQ: begin
                // Target acceptance wins over a watchdog expiry on the same edge.
                if (lmmi_ready) begin
                    lmmi_request_d = 1'b0;
                    if (lmmi_wr_rdn) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = '0;
                        rsp_err_d   = 1'b0;
                    end else if (lmmi_rdata_valid) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = lmmi_rdata;
                        rsp_err_d   = 1'b0;
                    end else begin
                        state_d = WAIT_RD;
                    end
                end else if (timeout_hit) begin
                    lmmi_request_d = 1'b0;
                    state_d        = RESP;
                    rsp_valid_d    = 1'b1;
                    rsp_rdata_d    = '0;
                    rsp_err_d      = 1'b1;
                end
            end
            WAIT_RD: begin
                if (lmmi_rdata_valid) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = lmmi_rdata;
                    rsp_err_d   = 1'b0;
                end else if (timeout_hit) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Registered, so it rises one cycle after the response handshake.
        cmd_ready_d = (state_d == IDLE);
    end

endmodule

// File: tb/tb_lmmi_initiator.sv
// Self-checking bench for lmmi_initiator: directed scenarios plus randomized traffic
// checked against a register-file reference model of the hard IP.
`timescale 1ns/1ps
module tb_lmmi_initiator;
    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 8;

    logic              lmmi_clk = 1'b0;
    logic              lmmi_resetn = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_write = 1'b0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [DATA_W-1:0] cmd_wdata = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              lmmi_request;
    logic              lmmi_wr_rdn;
    logic [ADDR_W-1:0] lmmi_offset;
    logic [DATA_W-1:0] lmmi_wdata;
    logic              lmmi_ready = 1'b0;
    logic              lmmi_rdata_valid = 1'b0;
    logic [DATA_W-1:0] lmmi_rdata = '0;

    int total_cnt = 0;
    int pass_cnt  = 0;
    int cyc = 0;
    int hs_cyc = 0;

    // ref_regs: what the register file should hold given the commands issued.
    // tgt_regs: what the emulated target holds given what actually arrived on LMMI.
    logic [7:0] ref_regs [256];
    logic [7:0] tgt_regs [256];

    lmmi_initiator #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .lmmi_clk(lmmi_clk), .lmmi_resetn(lmmi_resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .lmmi_request(lmmi_request), .lmmi_wr_rdn(lmmi_wr_rdn), .lmmi_offset(lmmi_offset),
        .lmmi_wdata(lmmi_wdata), .lmmi_ready(lmmi_ready),
        .lmmi_rdata_valid(lmmi_rdata_valid), .lmmi_rdata(lmmi_rdata)
    );

    always #5 lmmi_clk = ~lmmi_clk;
    always @(posedge lmmi_clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL global_time_limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge lmmi_clk);
        #1;
    endtask

    task automatic do_txn(input string name, input logic w, input logic [7:0] a, input logic [7:0] d,
                          input int rdy_dly, input int dat_dly, input int stall, input logic stray);
        logic [7:0] exp_rdata;
        exp_rdata = w ? 8'h00 : ref_regs[a];
        if (w) ref_regs[a] = d;

        for (int i = 0; i < 20 && cmd_ready !== 1'b1; i++) step();
        total_cnt++;
        if (cmd_ready !== 1'b1) $display("FAIL %s_cmd_ready got %b exp 1", name, cmd_ready);
        else pass_cnt++;

        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        step();
        hs_cyc = cyc;
        cmd_valid = 1'b0; cmd_write = $urandom; cmd_addr = $urandom; cmd_wdata = $urandom;

        total_cnt++;
        if ({lmmi_request, lmmi_wr_rdn, lmmi_offset, lmmi_wdata, cmd_ready} !== {1'b1, w, a, d, 1'b0})
            $display("FAIL %s_req_issue got req=%b wr=%b off=%h wd=%h crdy=%b exp 1 %b %h %h 0",
                     name, lmmi_request, lmmi_wr_rdn, lmmi_offset, lmmi_wdata, cmd_ready, w, a, d);
        else pass_cnt++;

        for (int i = 0; i < rdy_dly; i++) begin
            step();
            total_cnt++;
            if ({lmmi_request, lmmi_wr_rdn, lmmi_offset, lmmi_wdata, rsp_valid} !== {1'b1, w, a, d, 1'b0})
                $display("FAIL %s_req_hold got req=%b wr=%b off=%h wd=%h rv=%b exp 1 %b %h %h 0",
                         name, lmmi_request, lmmi_wr_rdn, lmmi_offset, lmmi_wdata, rsp_valid, w, a, d);
            else pass_cnt++;
        end

        lmmi_ready = 1'b1;
        if (lmmi_wr_rdn) tgt_regs[lmmi_offset] = lmmi_wdata;
        if (!w && dat_dly == 0) begin
            lmmi_rdata_valid = 1'b1;
            lmmi_rdata = tgt_regs[lmmi_offset];
        end
        step();
        lmmi_ready = 1'b0; lmmi_rdata_valid = 1'b0; lmmi_rdata = $urandom;
        total_cnt++;
        if (lmmi_request !== 1'b0) $display("FAIL %s_req_drop got %b exp 0", name, lmmi_request);
        else pass_cnt++;

        if (!w && dat_dly > 0) begin
            for (int i = 0; i < dat_dly - 1; i++) begin
                total_cnt++;
                if (rsp_valid !== 1'b0) $display("FAIL %s_wait_rd_rsp got %b exp 0", name, rsp_valid);
                else pass_cnt++;
                step();
            end
            lmmi_rdata_valid = 1'b1;
            lmmi_rdata = tgt_regs[lmmi_offset];
            step();
            lmmi_rdata_valid = 1'b0; lmmi_rdata = $urandom;
        end

        total_cnt++;
        if ({rsp_valid, rsp_rdata, rsp_err, cmd_ready} !== {1'b1, exp_rdata, 1'b0, 1'b0})
            $display("FAIL %s_rsp got v=%b d=%h e=%b crdy=%b exp 1 %h 0 0",
                     name, rsp_valid, rsp_rdata, rsp_err, cmd_ready, exp_rdata);
        else pass_cnt++;

        for (int i = 0; i < stall; i++) begin
            if (stray) begin
                lmmi_ready = 1'b1; lmmi_rdata_valid = 1'b1; lmmi_rdata = $urandom;
            end
            step();
            lmmi_ready = 1'b0; lmmi_rdata_valid = 1'b0;
            total_cnt++;
            if ({rsp_valid, rsp_rdata, rsp_err, lmmi_request, cmd_ready} !== {1'b1, exp_rdata, 1'b0, 1'b0, 1'b0})
                $display("FAIL %s_rsp_stall got v=%b d=%h e=%b req=%b crdy=%b exp 1 %h 0 0 0",
                         name, rsp_valid, rsp_rdata, rsp_err, lmmi_request, cmd_ready, exp_rdata);
            else pass_cnt++;
        end

        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        total_cnt++;
        if ({rsp_valid, cmd_ready} !== 2'b01)
            $display("FAIL %s_rsp_done got v=%b crdy=%b exp 0 1", name, rsp_valid, cmd_ready);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        step(); step(); step();
        total_cnt++;
        if ({cmd_ready, rsp_valid, rsp_rdata, rsp_err, lmmi_request, lmmi_wr_rdn, lmmi_offset, lmmi_wdata} !== '0)
            $display("FAIL reset_outputs got crdy=%b rv=%b rd=%h err=%b req=%b wr=%b off=%h wd=%h exp all 0",
                     cmd_ready, rsp_valid, rsp_rdata, rsp_err, lmmi_request, lmmi_wr_rdn, lmmi_offset, lmmi_wdata);
        else pass_cnt++;
        lmmi_resetn = 1'b1;
        total_cnt++;
        if (cmd_ready !== 1'b0) $display("FAIL reset_release_same_cycle got %b exp 0", cmd_ready);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({cmd_ready, rsp_valid, lmmi_request} !== 3'b100)
            $display("FAIL reset_release_edge got crdy=%b rv=%b req=%b exp 1 0 0", cmd_ready, rsp_valid, lmmi_request);
        else pass_cnt++;
    endtask

    task automatic test_write();
        do_txn("write", 1'b1, 8'h12, 8'hA5, 0, 0, 2, 1'b0);
    endtask

    task automatic test_read_wait();
        ref_regs[8'h3C] = 8'h5A;
        tgt_regs[8'h3C] = 8'h5A;
        do_txn("read_wait", 1'b0, 8'h3C, 8'h00, 3, 2, 4, 1'b1);
    endtask

    task automatic test_read_same_cycle();
        ref_regs[8'h40] = 8'h77;
        tgt_regs[8'h40] = 8'h77;
        do_txn("read_same", 1'b0, 8'h40, 8'hC3, 1, 0, 1, 1'b0);
        do_txn("read_back", 1'b0, 8'h12, 8'h00, 0, 1, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        int first_hs;
        do_txn("b2b_a", 1'b1, 8'h20, 8'h11, 0, 0, 0, 1'b0);
        first_hs = hs_cyc;
        do_txn("b2b_b", 1'b1, 8'h21, 8'h22, 0, 0, 0, 1'b0);
        total_cnt++;
        if (hs_cyc - first_hs !== 3) $display("FAIL b2b_spacing got %0d exp 3", hs_cyc - first_hs);
        else pass_cnt++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            do_txn("rand", 1'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 4)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom));
        end
    endtask

    task automatic test_timeout();
        int n;
        n = 0;
        for (int i = 0; i < 20 && cmd_ready !== 1'b1; i++) step();
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h55; cmd_wdata = 8'h00;
        step();
        cmd_valid = 1'b0;
`ifdef LMMI_TIMEOUT_EN
        while (lmmi_request === 1'b1 && n < 40) begin
            n++;
            step();
        end
        total_cnt++;
        if (n < TIMEOUT || n > TIMEOUT + 2) $display("FAIL timeout_req_cycles got %0d exp %0d..%0d", n, TIMEOUT, TIMEOUT + 2);
        else pass_cnt++;
        total_cnt++;
        if ({lmmi_request, rsp_valid, rsp_err, rsp_rdata} !== {1'b0, 1'b1, 1'b1, 8'h00})
            $display("FAIL timeout_rsp got req=%b v=%b e=%b d=%h exp 0 1 1 00", lmmi_request, rsp_valid, rsp_err, rsp_rdata);
        else pass_cnt++;
        lmmi_rdata_valid = 1'b1; lmmi_rdata = 8'hEE;
        step();
        lmmi_rdata_valid = 1'b0;
        step();
        total_cnt++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b1, 8'h00})
            $display("FAIL timeout_stray got v=%b e=%b d=%h exp 1 1 00", rsp_valid, rsp_err, rsp_rdata);
        else pass_cnt++;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        total_cnt++;
        if ({rsp_valid, cmd_ready} !== 2'b01) $display("FAIL timeout_done got v=%b crdy=%b exp 0 1", rsp_valid, cmd_ready);
        else pass_cnt++;
`else
        while (lmmi_request === 1'b1 && rsp_valid === 1'b0 && n < 40) begin
            n++;
            step();
        end
        total_cnt++;
        if (n !== 40 || rsp_err !== 1'b0)
            $display("FAIL no_watchdog_wait got cycles=%0d err=%b exp 40 0", n, rsp_err);
        else pass_cnt++;
        lmmi_resetn = 1'b0;
        step();
        lmmi_resetn = 1'b1;
        step();
        total_cnt++;
        if ({cmd_ready, lmmi_request, rsp_valid} !== 3'b100)
            $display("FAIL no_watchdog_recover got crdy=%b req=%b v=%b exp 1 0 0", cmd_ready, lmmi_request, rsp_valid);
        else pass_cnt++;
`endif
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 20 && cmd_ready !== 1'b1; i++) step();
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h3C; cmd_wdata = 8'h99;
        step();
        cmd_valid = 1'b0;
        lmmi_ready = 1'b1;
        step();
        lmmi_ready = 1'b0;
        step();
        #2 lmmi_resetn = 1'b0;
        #1;
        total_cnt++;
        if ({cmd_ready, rsp_valid, rsp_rdata, rsp_err, lmmi_request, lmmi_wr_rdn, lmmi_offset, lmmi_wdata} !== '0)
            $display("FAIL reset_mid_async got crdy=%b rv=%b rd=%h err=%b req=%b wr=%b off=%h wd=%h exp all 0",
                     cmd_ready, rsp_valid, rsp_rdata, rsp_err, lmmi_request, lmmi_wr_rdn, lmmi_offset, lmmi_wdata);
        else pass_cnt++;
        step();
        lmmi_resetn = 1'b1;
        lmmi_rdata_valid = 1'b1; lmmi_rdata = 8'h5A;
        step();
        lmmi_rdata_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if ({rsp_valid, lmmi_request, cmd_ready} !== 3'b001)
                $display("FAIL reset_mid_no_rsp got v=%b req=%b crdy=%b exp 0 0 1", rsp_valid, lmmi_request, cmd_ready);
            else pass_cnt++;
            step();
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ref_regs[i] = 8'($urandom);
            tgt_regs[i] = ref_regs[i];
        end
        test_reset();
        test_write();
        test_read_wait();
        test_read_same_cycle();
        test_back_to_back();
        test_random();
        test_timeout();
        test_reset_mid();
        do_txn("after_reset", 1'b0, 8'h20, 8'h00, 1, 1, 1, 1'b0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
